an_encoder_seq: RTL and testbench

- Sequential AN-code encoder. Computes code = A*N by iterative shift-and-add over the set bits of constant A (default A=13, 8-bit N, 12-bit code).
- Transmit-side counterpart of the AN decoder. Its output word matches the decoder's ANe input format.
- Optional single-bit error injection lets benches generate the corrupted codewords the decoder must correct.
- Valid/ready handshake on both sides.

---
 rtl/an_encoder_seq.sv | 127 ++++++++++++
 tb/tb_an_encoder_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/an_encoder_seq.sv
// Sequential AN-code encoder: code = A*N built by shift-and-add over the bits of A,
// one bit per cycle, with optional single-bit error injection on the finished codeword.
module an_encoder_seq #(
   parameter int A     = 13,
   parameter int K     = 8,
   parameter int CW    = 12,
   parameter int ABITS = $clog2(A + 1),
   parameter int EW    = $clog2(CW)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [K-1:0]  data_in,
   input  logic          err_en,
   input  logic [EW-1:0] err_pos,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [CW-1:0] code_out,
   output logic [15:0]   word_cnt
);

   if (((longint'(1) << K) - 1) * A > (longint'(1) << CW) - 1) begin : g_cw_too_narrow
      $error("an_encoder_seq: (2^K-1)*A does not fit in CW bits");
   end
   if (A < 3 || (A % 2) == 0) begin : g_bad_a
      $error("an_encoder_seq: A must be odd and >= 3");
   end

   localparam int IW = (ABITS > 1) ? $clog2(ABITS) : 1;
   localparam logic [ABITS-1:0] A_VEC    = ABITS'(A);
   localparam logic [IW-1:0]    IDX_LAST = IW'(ABITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   acc_q, acc_d;
   logic [CW-1:0]   mcand_q, mcand_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            een_q, een_d;
   logic [EW-1:0]   epos_q, epos_d;
   logic [CW-1:0]   code_q, code_d;
   logic [15:0]     cnt_q, cnt_d;

   logic [CW-1:0]   partial, sum, flip;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         mcand_q <= '0;
         idx_q   <= '0;
         een_q   <= 1'b0;
         epos_q  <= '0;
         code_q  <= '0;
         cnt_q   <= '0;
      end else begin
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         idx_q   <= idx_d;
         een_q   <= een_d;
         epos_q  <= epos_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
      end
   end

   // Positions at or beyond CW leave the codeword untouched.
   always_comb begin
      partial = A_VEC[idx_q] ? (mcand_q << idx_q) : '0;
      sum     = acc_q + partial;
      flip    = '0;
      if (een_q && ({1'b0, epos_q} < (EW+1)'(CW)))
         flip = {{(CW-1){1'b0}}, 1'b1} << epos_q;
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      idx_d   = idx_q;
      een_d   = een_q;
      epos_d  = epos_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d = CW'(data_in);
               een_d   = err_en;
               epos_d  = err_pos;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            acc_d = sum;
            idx_d = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
               code_d  = sum ^ flip;
               idx_d   = '0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               cnt_d   = cnt_q + 16'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      code_out  = code_q;
      word_cnt  = cnt_q;
   end

endmodule

// File: tb/tb_an_encoder_seq.sv
// Randomized + directed bench for an_encoder_seq; expected codewords come from
// plain N*A arithmetic and are checked by a decoupled output monitor.
module tb_an_encoder_seq;
   localparam int A = 13, K = 8, CW = 12, ABITS = 4, EW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [K-1:0]  data_in;
   logic          err_en;
   logic [EW-1:0] err_pos;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] code_out;
   logic [15:0]   word_cnt;

   an_encoder_seq #(.A(A), .K(K), .CW(CW), .ABITS(ABITS), .EW(EW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .err_en(err_en), .err_pos(err_pos),
      .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
      .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CW-1:0] code;
      bit            ef;
      int            acc;
   } exp_t;

   exp_t        q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [15:0] exp_cnt = 16'd0;
   bit          cnt_chk = 1'b0;
   int          hs_cyc = 0;
   int          last_acc = 0;
   bit          rand_rdy = 1'b0;
   logic        or_fixed = 1'b1;
   bit          prev_vld = 1'b0;
   logic [CW-1:0] prev_code = '0;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : or_fixed;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model(input int n, input bit een, input int epos);
      int v;
      v = (n * A) % (1 << CW);
      if (een && epos < CW) v = v ^ (1 << epos);
      return v;
   endfunction

   // Monitor: samples on the falling edge, handshake completes on the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_vld = 1'b0;
      end else begin
         if (cnt_chk) begin
            chk("word_cnt", word_cnt, exp_cnt);
            cnt_chk = 1'b0;
         end
         if (out_valid && !prev_vld) begin
            if (q.size() == 0) chk("unexpected_output", 1, 0);
            else               chk("latency", cyc - q[0].acc, ABITS);
         end
         if (out_valid && prev_vld) chk("code_stable", code_out, prev_code);
         if (out_valid) chk("in_ready_low_in_done", in_ready, 0);
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("output_without_input", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("code_out", code_out, e.code);
               if (e.ef) chk("mod13", code_out % A, 0);
            end
            exp_cnt = exp_cnt + 16'd1;
            cnt_chk = 1'b1;
            hs_cyc  = cyc + 1;
         end
         prev_vld  = out_valid;
         prev_code = code_out;
      end
   end

   task automatic send(input int n, input bit een, input int epos);
      int t;
      exp_t e;
      @(negedge clk);
      data_in  = K'(n);
      err_en   = een;
      err_pos  = EW'(epos);
      in_valid = 1'b1;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 0, 1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         @(negedge clk);
         last_acc = cyc;
         e.code = CW'(model(n, een, epos));
         e.ef   = !(een && epos < CW);
         e.acc  = cyc;
         q.push_back(e);
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((q.size() != 0 || out_valid) && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      int t;
      int ep[5] = '{0, 1, 2, 3, 7};
      rst_n = 1'b0; in_valid = 1'b0; data_in = '0; err_en = 1'b0; err_pos = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_code_out", code_out, 0);
      chk("rst_word_cnt", word_cnt, 0);
      rst_n = 1'b1;

      send(11, 0, 0);
      drain();
      chk("first_word_cnt", word_cnt, 1);

      foreach (ep[i]) send(11, 1'b1, ep[i]);
      send(0, 0, 0);
      send(255, 0, 0);
      for (int p = 12; p < 16; p++) send(255, 1'b1, p);
      drain();

      // Backpressure with a second word waiting upstream.
      or_fixed = 1'b0;
      send(77, 0, 0);
      t = 0;
      while (!out_valid && t < 50) begin @(negedge clk); t++; end
      chk("bp_out_valid", out_valid, 1);
      fork send(99, 0, 0); join_none
      repeat (10) begin
         @(negedge clk);
         chk("bp_in_ready", in_ready, 0);
         chk("bp_hold_valid", out_valid, 1);
      end
      or_fixed = 1'b1;
      wait fork;
      chk("bp_accept_gap", last_acc - hs_cyc, 1);
      drain();

      rand_rdy = 1'b1;
      repeat (40) send($urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 15));
      drain();
      rand_rdy = 1'b0;
      repeat (2) @(negedge clk);

      // Abort a word in flight.
      send(200, 0, 0);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_code_out", code_out, 0);
      chk("abort_word_cnt", word_cnt, 0);
      void'(q.pop_back());
      exp_cnt = 16'd0;
      cnt_chk = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      send(5, 0, 0);
      drain();
      chk("abort_recover_cnt", word_cnt, 1);
      chk("abort_recover_code", code_out, 65);

      // Counter wrap via preload.
      @(negedge clk);
      force dut.cnt_q = 16'hFFFE;
      #1;
      release dut.cnt_q;
      exp_cnt = 16'hFFFE;
      send(3, 0, 0);
      send(4, 0, 0);
      drain();
      chk("cnt_wrap", word_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
